axi2mem_rd_burst_sched: RTL and testbench

- Read-command scheduler in front of the two-lane TCDM read path of the axi2mem bridge.
- Accepts one AXI read burst (AR-channel fields) at a time and splits it into per-beat, per-lane 32-bit word commands on the two trans_rd lanes.
- Lane 0 carries the low word of each 64-bit beat; lane 1 carries the high word.
- Each lane is handshaked independently; the block sequences INCR, FIXED and WRAP address generation.

---
 rtl/axi2mem_rd_burst_sched.sv | 154 +++++++++++++++
 tb/tb_axi2mem_rd_burst_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/axi2mem_rd_burst_sched.sv
// Read-burst command scheduler for the axi2mem TCDM read path: splits one AXI AR burst
// into per-beat word requests on two independently handshaked lanes (lane 0 low word, lane 1 high word).
//
// state | meaning
// IDLE  | waiting for an AR command; cmd_ready_o high except for one bubble after a burst or reset
// BURST | issuing the current beat on both lanes until each lane is granted
module axi2mem_rd_burst_sched #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ID_WIDTH-1:0]     cmd_id_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [1:0]              cmd_burst_i,
    output logic [1:0]              trans_rd_req_o,
    input  logic [1:0]              trans_rd_gnt_i,
    output logic [2*ADDR_WIDTH-1:0] trans_rd_add_o,
    output logic [2*ID_WIDTH-1:0]   trans_rd_id_o,
    output logic [1:0]              trans_rd_last_o,
    output logic                    busy_o,
    output logic                    wrap_err_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    state_t                 state_q;
    state_t                 state_d;
    logic                   ready_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [1:0]             burst_q;
    logic [LEN_WIDTH-1:0]   beats_left_q;
    logic [ADDR_WIDTH-1:0]  beat_addr_q;
    logic [ADDR_WIDTH-1:0]  wrap_mask_q;
    logic [1:0]             done_q;
    logic                   wrap_err_q;

    logic                   cmd_accept;
    logic                   busy;
    logic [1:0]             lane_req;
    logic [1:0]             lane_granted;
    logic                   beat_done;
    logic                   last_beat;
    logic                   wrap_len_ok;
    logic                   wrap_illegal;
    logic [ADDR_WIDTH-1:0]  incr_addr;
    logic [ADDR_WIDTH-1:0]  next_addr;

    assign last_beat    = (beats_left_q == '0);
    assign lane_granted = lane_req & trans_rd_gnt_i;

    assign wrap_len_ok  = (cmd_len_i == LEN_WIDTH'(1)) || (cmd_len_i == LEN_WIDTH'(3)) ||
                          (cmd_len_i == LEN_WIDTH'(7)) || (cmd_len_i == LEN_WIDTH'(15));
    assign wrap_illegal = (cmd_burst_i == BURST_WRAP) && !wrap_len_ok;

    // Wrap keeps the bits above the mask and lets the incremented low bits roll over inside it.
    assign incr_addr = beat_addr_q + ADDR_WIDTH'(8);
    always_comb begin
        next_addr = incr_addr;
        case (burst_q)
            BURST_FIXED: next_addr = beat_addr_q;
            BURST_WRAP:  next_addr = (beat_addr_q & ~wrap_mask_q) | (incr_addr & wrap_mask_q);
            default:     next_addr = incr_addr;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_accept = 1'b0;
        busy       = 1'b0;
        lane_req   = 2'b00;
        beat_done  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_accept = ready_q && cmd_valid_i;
                if (cmd_accept) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                busy      = 1'b1;
                lane_req  = ~done_q;
                beat_done = &(done_q | (~done_q & trans_rd_gnt_i));
                if (beat_done && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q      <= 1'b0;
            id_q         <= '0;
            burst_q      <= BURST_INCR;
            beats_left_q <= '0;
            beat_addr_q  <= '0;
            wrap_mask_q  <= '0;
            done_q       <= 2'b00;
            wrap_err_q   <= 1'b0;
        end else begin
            // Registered ready gives the one-cycle bubble after a burst and after reset.
            ready_q    <= (state_q == IDLE) && !cmd_accept;
            wrap_err_q <= cmd_accept && wrap_illegal;
            if (cmd_accept) begin
                id_q         <= cmd_id_i;
                burst_q      <= wrap_illegal ? BURST_INCR : cmd_burst_i;
                beats_left_q <= cmd_len_i;
                beat_addr_q  <= cmd_addr_i & ~ADDR_WIDTH'(7);
                wrap_mask_q  <= ADDR_WIDTH'({cmd_len_i, 3'b111});
                done_q       <= 2'b00;
            end else if (state_q == BURST) begin
                if (beat_done) begin
                    done_q <= 2'b00;
                    if (!last_beat) begin
                        beats_left_q <= beats_left_q - LEN_WIDTH'(1);
                        beat_addr_q  <= next_addr;
                    end
                end else begin
                    done_q <= done_q | lane_granted;
                end
            end
        end
    end

    assign cmd_ready_o     = ready_q;
    assign busy_o          = busy;
    assign wrap_err_o      = wrap_err_q;
    assign trans_rd_req_o  = lane_req;
    assign trans_rd_add_o  = busy ? {beat_addr_q + ADDR_WIDTH'(4), beat_addr_q} : '0;
    assign trans_rd_id_o   = busy ? {id_q, id_q} : '0;
    assign trans_rd_last_o = (busy && last_beat) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_axi2mem_rd_burst_sched.sv
// Directed testbench for axi2mem_rd_burst_sched: all checks and input changes happen on the
// falling edge, with hand-computed lane-0 address sequences (lane 1 = lane 0 + 4).
module tb_axi2mem_rd_burst_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_burst;
    logic [1:0]  trans_rd_req;
    logic [1:0]  trans_rd_gnt;
    logic [63:0] trans_rd_add;
    logic [11:0] trans_rd_id;
    logic [1:0]  trans_rd_last;
    logic        busy;
    logic        wrap_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi2mem_rd_burst_sched #(
        .ID_WIDTH   (6),
        .ADDR_WIDTH (32),
        .LEN_WIDTH  (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_id_i        (cmd_id),
        .cmd_addr_i      (cmd_addr),
        .cmd_len_i       (cmd_len),
        .cmd_burst_i     (cmd_burst),
        .trans_rd_req_o  (trans_rd_req),
        .trans_rd_gnt_i  (trans_rd_gnt),
        .trans_rd_add_o  (trans_rd_add),
        .trans_rd_id_o   (trans_rd_id),
        .trans_rd_last_o (trans_rd_last),
        .busy_o          (busy),
        .wrap_err_o      (wrap_err)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the first request cycle.
    task automatic issue(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
        int n;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_burst = burst;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] lo, input logic last, input logic [5:0] id);
        chk({tag, "_req"},  {62'd0, trans_rd_req}, 64'd3);
        chk({tag, "_add"},  trans_rd_add, {lo + 32'd4, lo});
        chk({tag, "_last"}, {62'd0, trans_rd_last}, last ? 64'd3 : 64'd0);
        chk({tag, "_id"},   {52'd0, trans_rd_id}, {52'd0, id, id});
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_id       = '0;
        cmd_addr     = '0;
        cmd_len      = '0;
        cmd_burst    = '0;
        trans_rd_gnt = 2'b00;

        @(negedge clk);
        chk("rst_ready",    {63'd0, cmd_ready}, 64'd0);
        chk("rst_req",      {62'd0, trans_rd_req}, 64'd0);
        chk("rst_add",      trans_rd_add, 64'd0);
        chk("rst_id",       {52'd0, trans_rd_id}, 64'd0);
        chk("rst_last",     {62'd0, trans_rd_last}, 64'd0);
        chk("rst_busy",     {63'd0, busy}, 64'd0);
        chk("rst_wrap_err", {63'd0, wrap_err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

        // INCR 0x1000 len 3, grants tied high
        trans_rd_gnt = 2'b11;
        issue(6'd5, 32'h0000_1000, 8'd3, 2'b01);
        chk("incr_busy", {63'd0, busy}, 64'd1);
        beat("incr_b0", 32'h0000_1000, 1'b0, 6'd5);
        beat("incr_b1", 32'h0000_1008, 1'b0, 6'd5);
        beat("incr_b2", 32'h0000_1010, 1'b0, 6'd5);
        beat("incr_b3", 32'h0000_1018, 1'b1, 6'd5);
        chk("incr_bubble_ready", {63'd0, cmd_ready}, 64'd0);
        chk("incr_end_req",      {62'd0, trans_rd_req}, 64'd0);
        chk("incr_end_busy",     {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("incr_ready_n6",     {63'd0, cmd_ready}, 64'd1);

        // legal WRAP len 3 starting at 0x2018
        issue(6'd2, 32'h0000_2018, 8'd3, 2'b10);
        chk("wrap_err_legal", {63'd0, wrap_err}, 64'd0);
        beat("wrap_b0", 32'h0000_2018, 1'b0, 6'd2);
        beat("wrap_b1", 32'h0000_2000, 1'b0, 6'd2);
        beat("wrap_b2", 32'h0000_2008, 1'b0, 6'd2);
        beat("wrap_b3", 32'h0000_2010, 1'b1, 6'd2);

        // WRAP with illegal len 2 falls back to INCR
        issue(6'd3, 32'h0000_3010, 8'd2, 2'b10);
        chk("wrap_err_pulse", {63'd0, wrap_err}, 64'd1);
        beat("wbad_b0", 32'h0000_3010, 1'b0, 6'd3);
        chk("wrap_err_clear", {63'd0, wrap_err}, 64'd0);
        beat("wbad_b1", 32'h0000_3018, 1'b0, 6'd3);
        beat("wbad_b2", 32'h0000_3020, 1'b1, 6'd3);

        // skewed grants: lane 0 immediately, lane 1 after three cycles
        trans_rd_gnt = 2'b01;
        issue(6'd9, 32'h0000_5000, 8'd1, 2'b01);
        chk("skew_c1_req", {62'd0, trans_rd_req}, 64'd3);
        chk("skew_c1_add", trans_rd_add, 64'h0000_5004_0000_5000);
        @(negedge clk);
        chk("skew_c2_req",  {62'd0, trans_rd_req}, 64'd2);
        chk("skew_c2_add",  trans_rd_add, 64'h0000_5004_0000_5000);
        chk("skew_c2_last", {62'd0, trans_rd_last}, 64'd0);
        @(negedge clk);
        chk("skew_c3_req",  {62'd0, trans_rd_req}, 64'd2);
        @(negedge clk);
        chk("skew_c4_req",  {62'd0, trans_rd_req}, 64'd2);
        chk("skew_c4_add",  trans_rd_add, 64'h0000_5004_0000_5000);
        trans_rd_gnt = 2'b11;
        @(negedge clk);
        beat("skew_b1", 32'h0000_5008, 1'b1, 6'd9);

        // FIXED len 2, then unaligned single-beat INCR
        issue(6'd1, 32'h0000_0040, 8'd2, 2'b00);
        beat("fixed_b0", 32'h0000_0040, 1'b0, 6'd1);
        beat("fixed_b1", 32'h0000_0040, 1'b0, 6'd1);
        beat("fixed_b2", 32'h0000_0040, 1'b1, 6'd1);
        issue(6'd4, 32'h0000_4005, 8'd0, 2'b01);
        beat("unal_b0", 32'h0000_4000, 1'b1, 6'd4);
        chk("unal_end_busy", {63'd0, busy}, 64'd0);

        // reserved burst type behaves as INCR
        issue(6'd7, 32'h0000_7000, 8'd1, 2'b11);
        beat("rsv_b0", 32'h0000_7000, 1'b0, 6'd7);
        beat("rsv_b1", 32'h0000_7008, 1'b1, 6'd7);

        // reset during beat 2 of a len-7 INCR
        issue(6'd17, 32'h0000_6000, 8'd7, 2'b01);
        beat("mrst_b0", 32'h0000_6000, 1'b0, 6'd17);
        beat("mrst_b1", 32'h0000_6008, 1'b0, 6'd17);
        chk("mrst_b2_add", trans_rd_add, 64'h0000_6014_0000_6010);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_req",   {62'd0, trans_rd_req}, 64'd0);
        chk("mrst_add",   trans_rd_add, 64'd0);
        chk("mrst_last",  {62'd0, trans_rd_last}, 64'd0);
        chk("mrst_id",    {52'd0, trans_rd_id}, 64'd0);
        chk("mrst_busy",  {63'd0, busy}, 64'd0);
        chk("mrst_ready", {63'd0, cmd_ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_after_req",   {62'd0, trans_rd_req}, 64'd0);
        chk("mrst_after_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        chk("mrst_after2_req",  {62'd0, trans_rd_req}, 64'd0);

        // address roll-over at the top of the address space
        issue(6'd63, 32'hFFFF_FFF8, 8'd1, 2'b01);
        beat("top_b0", 32'hFFFF_FFF8, 1'b0, 6'd63);
        beat("top_b1", 32'h0000_0000, 1'b1, 6'd63);
        chk("top_end_busy", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
